// File: rtl/vc_flow_injector.sv
// Per-VC single-word holding stage feeding QoS, with round-robin arbitration,
// per-VC pause/resume tracking and an IDLE/RUN/DRAIN injection gate.

module vc_hold_slot #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb_i,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic          pausa_i,
  input  logic          continuar_i,
  input  logic [DW-1:0] din_i,
  output logic          full_o,
  output logic          paused_o,
  output logic [DW-1:0] dout_o
);
  logic          full_q, paused_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q   <= 1'b0;
      paused_q <= 1'b0;
      data_q   <= '0;
    end else if (enb_i) begin
      // pausa dominates when both flow-control requests arrive together
      if (pausa_i)          paused_q <= 1'b1;
      else if (continuar_i) paused_q <= 1'b0;
      // a refill in the same cycle as a drain keeps the slot full with new data
      if (load_i) begin
        full_q <= 1'b1;
        data_q <= din_i;
      end else if (drain_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign full_o   = full_q;
  assign paused_o = paused_q;
  assign dout_o   = data_q;
endmodule

module vc_flow_injector #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int BUF_WIDTH      = 3,
  parameter int CNT_BITS       = 16,
  localparam int VCW = $clog2(QUEUE_QUANTITY),
  localparam int DW  = BUF_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic                      iniciar,
  input  logic                      detener,
  input  logic                      in_valid,
  input  logic [VCW-1:0]            in_vc,
  input  logic [DW-1:0]             in_data,
  output logic                      in_ready,
  input  logic [QUEUE_QUANTITY-1:0] pausa,
  input  logic [QUEUE_QUANTITY-1:0] continuar,
  output logic                      push,
  output logic [VCW-1:0]            vc_id,
  output logic [DW-1:0]             data_word,
  output logic [QUEUE_QUANTITY-1:0] paused,
  output logic                      idle,
  output logic [CNT_BITS-1:0]       word_count
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                               state_q, state_d;
  logic   [VCW-1:0]                     ptr_q, ptr_d;
  logic                                 push_q;
  logic   [VCW-1:0]                     vc_id_q;
  logic   [DW-1:0]                      data_word_q;
  logic   [CNT_BITS-1:0]                cnt_q, cnt_d;

  logic   [QUEUE_QUANTITY-1:0]          full, paused_w, eligible, load, drain;
  logic   [QUEUE_QUANTITY-1:0][DW-1:0]  hold_data;
  logic                                 grant_vld;
  logic   [VCW-1:0]                     grant_idx, idx;
  logic                                 accept;

  for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_slot
    assign load[i]  = accept & (in_vc == VCW'(i));
    assign drain[i] = grant_vld & (grant_idx == VCW'(i));
    vc_hold_slot #(.DW(DW)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .enb_i       (enb),
      .load_i      (load[i]),
      .drain_i     (drain[i]),
      .pausa_i     (pausa[i]),
      .continuar_i (continuar[i]),
      .din_i       (in_data),
      .full_o      (full[i]),
      .paused_o    (paused_w[i]),
      .dout_o      (hold_data[i])
    );
  end

  // A VC raising pausa this cycle is excluded before its pause bit registers.
  assign eligible = full & ~paused_w & ~pausa;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    if (enb && state_q != S_IDLE) begin
      for (int k = 0; k < QUEUE_QUANTITY; k++) begin
        idx = ptr_q + VCW'(k);
        if (!grant_vld && eligible[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
    end
  end

  assign in_ready = enb & (state_q == S_RUN) &
                    (~full[in_vc] | (grant_vld & (grant_idx == in_vc)));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (grant_vld) begin
      ptr_d = grant_idx + VCW'(1);
      cnt_d = cnt_q + CNT_BITS'(1);
    end
    case (state_q)
      S_IDLE:  if (iniciar) state_d = S_RUN;
      S_RUN:   if (detener) state_d = S_DRAIN;
      S_DRAIN: if (~|full && !push_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      push_q      <= 1'b0;
      vc_id_q     <= '0;
      data_word_q <= '0;
      cnt_q       <= '0;
    end else if (enb) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      push_q  <= grant_vld;
      if (grant_vld) begin
        vc_id_q     <= grant_idx;
        data_word_q <= hold_data[grant_idx];
      end
    end
  end

  // push_q is frozen with enb low, so the word reappears once enb returns
  assign push       = push_q & enb;
  assign vc_id      = vc_id_q;
  assign data_word  = data_word_q;
  assign paused     = paused_w;
  assign idle       = (state_q == S_IDLE);
  assign word_count = cnt_q;
endmodule

// File: tb/tb_vc_flow_injector.sv
// Directed bench for vc_flow_injector: expected pushes are queued when stimulus
// is driven and matched against DUT pushes sampled on the falling edge.

module tb_vc_flow_injector;
  logic        clk = 1'b0;
  logic        rst, enb, iniciar, detener, in_valid, in_ready;
  logic [1:0]  in_vc, vc_id;
  logic [3:0]  in_data, data_word, pausa, continuar, paused;
  logic        push, idle;
  logic [15:0] word_count;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct packed {logic [1:0] vc; logic [3:0] d;} exp_t;
  exp_t sb[$];

  vc_flow_injector #(.QUEUE_QUANTITY(4), .BUF_WIDTH(3), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar), .detener(detener),
    .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data), .in_ready(in_ready),
    .pausa(pausa), .continuar(continuar), .push(push), .vc_id(vc_id),
    .data_word(data_word), .paused(paused), .idle(idle), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic expect_w(input logic [1:0] vc, input logic [3:0] d);
    sb.push_back({vc, d});
  endtask

  task automatic monitor();
    exp_t e;
    if (push === 1'b1) begin
      if (sb.size() == 0) chk("spurious_push", 32'(push), 32'd0);
      else begin
        e = sb.pop_front();
        chk("push_vc", 32'(vc_id), 32'(e.vc));
        chk("push_data", 32'(data_word), 32'(e.d));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic offer(input logic [1:0] vc, input logic [3:0] d);
    in_valid = 1'b1; in_vc = vc; in_data = d;
    #1 chk("in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("sb_drain", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b0; enb = 1'b1; iniciar = 1'b0; detener = 1'b0;
    in_valid = 1'b0; in_vc = '0; in_data = '0; pausa = '0; continuar = '0;
    #12;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_cnt", 32'(word_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 1'b1;

    // 1: in-order injection, one cycle latency
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    chk("run_idle", 32'(idle), 32'd0);
    expect_w(0, 8); expect_w(1, 5); expect_w(2, 2); expect_w(3, 3);
    offer(0, 8);
    chk("lat_no_push", 32'(push), 32'd0);
    offer(1, 5);
    chk("lat_push", 32'(push), 32'd1);
    offer(2, 2); offer(3, 3);
    wait_drain();
    chk("cnt_4", 32'(word_count), 32'd4);

    // 2: pointer moved to 2, all holds full -> 2,3,0,1
    expect_w(1, 6); offer(1, 6); wait_drain();
    pausa = 4'hF;
    offer(0, 1); offer(1, 2); offer(2, 3); offer(3, 4);
    chk("all_paused", 32'(paused), 32'hF);
    pausa = 4'h0; continuar = 4'hF; tick(); continuar = 4'h0;
    expect_w(2, 3); expect_w(3, 4); expect_w(0, 1); expect_w(1, 2);
    wait_drain();

    // 3: pause / resume on VC1
    pausa = 4'b0010; offer(1, 10); tick();
    chk("p1_set", 32'(paused), 32'b0010);
    continuar = 4'b0010; tick();
    chk("p1_both", 32'(paused), 32'b0010);
    pausa = 4'h0; tick(); continuar = 4'h0;
    chk("p1_clr", 32'(paused), 32'd0);
    expect_w(1, 10); wait_drain();

    // 4: drain with a paused VC
    pausa = 4'b1100; offer(2, 12); offer(3, 8);
    pausa = 4'h0; continuar = 4'b1000; detener = 1'b1; tick();
    detener = 1'b0; continuar = 4'h0;
    expect_w(3, 8);
    in_valid = 1'b1; in_vc = 2'd0; in_data = 4'd9;
    #1 chk("drain_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_drain();
    chk("drain_paused", 32'(paused), 32'b0100);
    repeat (3) tick();
    chk("drain_hold", 32'(idle), 32'd0);
    continuar = 4'b0100; tick(); continuar = 4'h0;
    expect_w(2, 12); wait_drain();
    for (int i = 0; i < 10 && idle !== 1'b1; i++) tick();
    chk("drain_idle", 32'(idle), 32'd1);

    // 5: asynchronous reset with holds full
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    pausa = 4'b0111; offer(0, 1); offer(1, 2); offer(2, 3);
    chk("r5_paused", 32'(paused), 32'b0111);
    #2 rst = 1'b0;
    #1;
    chk("r5_push", 32'(push), 32'd0);
    chk("r5_idle", 32'(idle), 32'd1);
    chk("r5_paused0", 32'(paused), 32'd0);
    chk("r5_cnt", 32'(word_count), 32'd0);
    chk("r5_vc", 32'(vc_id), 32'd0);
    chk("r5_data", 32'(data_word), 32'd0);
    chk("r5_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 1'b1; pausa = 4'h0;
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    repeat (6) tick();
    chk("r5_no_stale", 32'(word_count), 32'd0);

    // 6: counter wrap and enb freeze
    force dut.cnt_q = 16'hFFFF;
    #1 release dut.cnt_q;
    expect_w(0, 7); offer(0, 7); wait_drain();
    chk("cnt_wrap", 32'(word_count), 32'd0);
    offer(1, 4);
    enb = 1'b0; in_valid = 1'b1; in_vc = 2'd2; pausa = 4'b0001;
    #1 chk("enb0_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("enb0_push", 32'(push), 32'd0);
    end
    chk("enb0_cnt", 32'(word_count), 32'd0);
    chk("enb0_paused", 32'(paused), 32'd0);
    in_valid = 1'b0; pausa = 4'h0; enb = 1'b1;
    expect_w(1, 4); wait_drain();
    chk("cnt_after", 32'(word_count), 32'd1);
    tick();
    chk("sb_final", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
